// File: rtl/bip_pkg.sv
// bip_pkg: shared constants for the BIP control unit.
//   - opcode encodings (instr[15:11])
//   - control FSM state encodings
//   - accumulator input mux (selA) encodings
//   - ctrl_t: decoded control bundle produced by bip_instr_decoder
package bip_pkg;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [1:0] SELA_DM  = 2'b00;
    localparam logic [1:0] SELA_IMM = 2'b01;
    localparam logic [1:0] SELA_ALU = 2'b10;

    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       wr_acc;
        logic       wr_ram;
        logic       rd_ram;
        logic       is_hlt;
    } ctrl_t;

endpackage

// File: rtl/bip_instr_decoder.sv
// bip_instr_decoder: purely combinational opcode decode.
// Ports:
//   opcode  in   NB_OPCODE  instruction opcode field
//   ctrl    out  ctrl_t     selA/selB/op/wr_acc/wr_ram/rd_ram/is_hlt
// Strobes here are raw; the top level gates them with the execute enable.
module bip_instr_decoder
    import bip_pkg::*;
#(
    parameter int NB_OPCODE = 5
) (
    input  logic [NB_OPCODE-1:0] opcode,
    output ctrl_t                ctrl
);

    always_comb begin
        ctrl        = '0;
        ctrl.sel_a  = SELA_DM;
        case (opcode)
            OP_HLT: ctrl.is_hlt = 1'b1;
            OP_STO: ctrl.wr_ram = 1'b1;
            OP_LD: begin
                ctrl.sel_a  = SELA_DM;
                ctrl.wr_acc = 1'b1;
                ctrl.rd_ram = 1'b1;
            end
            OP_LDI: begin
                ctrl.sel_a  = SELA_IMM;
                ctrl.wr_acc = 1'b1;
            end
            OP_ADD: begin
                ctrl.sel_a  = SELA_ALU;
                ctrl.wr_acc = 1'b1;
                ctrl.rd_ram = 1'b1;
            end
            OP_ADDI: begin
                ctrl.sel_a  = SELA_ALU;
                ctrl.sel_b  = 1'b1;
                ctrl.wr_acc = 1'b1;
            end
            OP_SUB: begin
                ctrl.sel_a  = SELA_ALU;
                ctrl.op     = 1'b1;
                ctrl.wr_acc = 1'b1;
                ctrl.rd_ram = 1'b1;
            end
            OP_SUBI: begin
                ctrl.sel_a  = SELA_ALU;
                ctrl.sel_b  = 1'b1;
                ctrl.op     = 1'b1;
                ctrl.wr_acc = 1'b1;
            end
            default: ;  // unassigned opcodes behave as NOP
        endcase
    end

endmodule

// File: rtl/bip_control.sv
// bip_control: BIP accumulator processor control unit.
// Holds the PC, sequences execution from a start pulse until HLT, supports
// single-step, and counts executed instructions.
// Ports:
//   i_clk, i_reset          clock, async active-high reset
//   i_start                 start pulse (honoured in IDLE/HALT only)
//   i_step_mode, i_step     single-step mode select / per-instruction enable
//   i_instr                 program memory data at o_pc
//   o_pc                    program memory address
//   o_operand               instr[10:0] to datapath
//   o_selA, o_selB, o_op    datapath mux/ALU controls (ungated)
//   o_wr_acc, o_wr_ram, o_rd_ram  strobes, gated by exec
//   o_running, o_halt       state flags
//   o_cycles                instructions executed since last start (saturating)
//
// state   | meaning
// IDLE    | after reset, waiting for i_start
// RUN     | executing one instruction per exec cycle
// HALT    | HLT executed, waiting for i_start
module bip_control
    import bip_pkg::*;
#(
    parameter int NB_INSTR   = 16,
    parameter int NB_OPCODE  = 5,
    parameter int NB_OPERAND = 11,
    parameter int NB_PC      = 11,
    parameter int NB_CYCLES  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_step_mode,
    input  logic                  i_step,
    input  logic [NB_INSTR-1:0]   i_instr,
    output logic [NB_PC-1:0]      o_pc,
    output logic [NB_OPERAND-1:0] o_operand,
    output logic [1:0]            o_selA,
    output logic                  o_selB,
    output logic                  o_wr_acc,
    output logic                  o_op,
    output logic                  o_wr_ram,
    output logic                  o_rd_ram,
    output logic                  o_running,
    output logic                  o_halt,
    output logic [NB_CYCLES-1:0]  o_cycles
);

    localparam logic [NB_PC-1:0]     PC_ONE  = 1;
    localparam logic [NB_CYCLES-1:0] CYC_ONE = 1;

    logic [1:0]           state;
    logic                 step_mode;
    logic [NB_PC-1:0]     pc;
    logic [NB_CYCLES-1:0] cycles;
    logic                 exec;
    ctrl_t                dec;

    bip_instr_decoder #(
        .NB_OPCODE(NB_OPCODE)
    ) u_dec (
        .opcode(i_instr[NB_INSTR-1 -: NB_OPCODE]),
        .ctrl  (dec)
    );

    // Combinational from state, so an async reset kills the strobes at once.
    assign exec = (state == ST_RUN) && (!step_mode || i_step);

    assign o_operand = i_instr[NB_OPERAND-1:0];
    assign o_selA    = dec.sel_a;
    assign o_selB    = dec.sel_b;
    assign o_op      = dec.op;
    assign o_wr_acc  = exec & dec.wr_acc;
    assign o_wr_ram  = exec & dec.wr_ram;
    assign o_rd_ram  = exec & dec.rd_ram;
    assign o_pc      = pc;
    assign o_cycles  = cycles;
    assign o_running = (state == ST_RUN);
    assign o_halt    = (state == ST_HALT);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            step_mode <= 1'b0;
            pc        <= '0;
            cycles    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (i_start) begin
                        state     <= ST_RUN;
                        step_mode <= i_step_mode;
                        pc        <= '0;
                        cycles    <= '0;
                    end
                end
                ST_RUN: begin
                    if (exec) begin
                        if (cycles != '1)
                            cycles <= cycles + CYC_ONE;
                        if (dec.is_hlt)
                            state <= ST_HALT;
                        else
                            pc <= pc + PC_ONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bip_control.sv
module tb_bip_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, step_mode, step;
    logic [15:0] instr;
    logic [10:0] pc, operand;
    logic [1:0]  sel_a;
    logic        sel_b, wr_acc, op, wr_ram, rd_ram, running, halt;
    logic [15:0] cycles;

    logic [15:0] mem [0:2047];
    assign instr = mem[pc];

    always #5 clk = ~clk;

    bip_control dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_step_mode(step_mode),
        .i_step(step), .i_instr(instr), .o_pc(pc), .o_operand(operand),
        .o_selA(sel_a), .o_selB(sel_b), .o_wr_acc(wr_acc), .o_op(op),
        .o_wr_ram(wr_ram), .o_rd_ram(rd_ram), .o_running(running),
        .o_halt(halt), .o_cycles(cycles)
    );

    typedef struct {
        logic [10:0] pc;
        logic [10:0] operand;
        logic [1:0]  sela;
        logic        sela_chk;
        logic        selb;
        logic        op;
        logic        alu_chk;
        logic        wr_acc;
        logic        wr_ram;
        logic        rd_ram;
    } ev_t;

    ev_t q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [10:0] p, input logic [10:0] opd,
                        input logic [1:0] sa, input logic sa_c,
                        input logic sb, input logic o, input logic alu_c,
                        input logic wa, input logic wr, input logic rr);
        ev_t e;
        e.pc = p; e.operand = opd; e.sela = sa; e.sela_chk = sa_c;
        e.selb = sb; e.op = o; e.alu_chk = alu_c;
        e.wr_acc = wa; e.wr_ram = wr; e.rd_ram = rr;
        q.push_back(e);
    endtask

    // Monitor: every strobe the DUT presents must match the next queued event.
    always @(negedge clk) begin
        if (wr_acc || wr_ram || rd_ram) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe", {pc, wr_acc, wr_ram, rd_ram}, 32'h0);
            end else begin
                ev_t e;
                logic [31:0] a, x;
                e = q.pop_front();
                a = {3'b0, pc, operand, e.sela_chk ? sel_a : 2'b00,
                     e.alu_chk ? sel_b : 1'b0, e.alu_chk ? op : 1'b0,
                     wr_acc, wr_ram, rd_ram};
                x = {3'b0, e.pc, e.operand, e.sela_chk ? e.sela : 2'b00,
                     e.alu_chk ? e.selb : 1'b0, e.alu_chk ? e.op : 1'b0,
                     e.wr_acc, e.wr_ram, e.rd_ram};
                chk("strobe_event", a, x);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic sm);
        step_mode = sm;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_halt(input string name);
        bit seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (halt) begin
                seen = 1;
                break;
            end
        end
        chk({name, "_halt_reached"}, {31'b0, seen}, 32'h1);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0;
        clear_mem();
        // LDI 5; ADDI 3; STO 10; HLT
        mem[0] = {5'b00011, 11'd5};
        mem[1] = {5'b00101, 11'd3};
        mem[2] = {5'b00001, 11'd10};
        mem[3] = {5'b00000, 11'd0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", {21'b0, pc}, 32'h0);
        chk("rst_running", {31'b0, running}, 32'h0);
        chk("rst_halt", {31'b0, halt}, 32'h0);
        chk("rst_cycles", {16'b0, cycles}, 32'h0);
        chk("rst_strobes", {29'b0, wr_acc, wr_ram, rd_ram}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // Free run
        push(11'd0, 11'd5,  2'b01, 1, 0, 0, 0, 1, 0, 0);
        push(11'd1, 11'd3,  2'b10, 1, 1, 0, 1, 1, 0, 0);
        push(11'd2, 11'd10, 2'b00, 0, 0, 0, 0, 0, 1, 0);
        pulse_start(1'b0);
        wait_halt("run1");
        chk("run1_pc", {21'b0, pc}, 32'h3);
        chk("run1_cycles", {16'b0, cycles}, 32'h4);
        chk("run1_running", {31'b0, running}, 32'h0);

        // Step mode, pulses every 3rd cycle
        push(11'd0, 11'd5,  2'b01, 1, 0, 0, 0, 1, 0, 0);
        push(11'd1, 11'd3,  2'b10, 1, 1, 0, 1, 1, 0, 0);
        push(11'd2, 11'd10, 2'b00, 0, 0, 0, 0, 0, 1, 0);
        tick();
        pulse_start(1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            tick();
            @(negedge clk);
            chk("step_pc_hold", {21'b0, pc}, k);
            @(posedge clk); #1;
            step = 1'b1;
            tick();
            step = 1'b0;
            @(negedge clk);
            chk("step_pc_after", {21'b0, pc}, (k < 3) ? k + 1 : 3);
            @(posedge clk); #1;
        end
        chk("step_halt", {31'b0, halt}, 32'h1);
        chk("step_cycles", {16'b0, cycles}, 32'h4);

        // NOP (opcode 11111) then HLT
        clear_mem();
        mem[0] = {5'b11111, 11'h7FF};
        tick();
        pulse_start(1'b0);
        wait_halt("nop");
        chk("nop_pc", {21'b0, pc}, 32'h1);
        chk("nop_cycles", {16'b0, cycles}, 32'h2);

        // Async reset mid-run at PC 2
        clear_mem();
        for (int i = 0; i < 4; i++) mem[i] = {5'b00011, 11'(i + 1)};
        push(11'd0, 11'd1, 2'b01, 1, 0, 0, 0, 1, 0, 0);
        push(11'd1, 11'd2, 2'b01, 1, 0, 0, 0, 1, 0, 0);
        tick();
        pulse_start(1'b0);
        tick();
        tick();
        chk("mid_pc", {21'b0, pc}, 32'h2);
        #1;
        chk("mid_wr_acc", {31'b0, wr_acc}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_pc", {21'b0, pc}, 32'h0);
        chk("arst_running", {31'b0, running}, 32'h0);
        chk("arst_wr_acc", {31'b0, wr_acc}, 32'h0);
        chk("arst_cycles", {16'b0, cycles}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) push(11'(i), 11'(i + 1), 2'b01, 1, 0, 0, 0, 1, 0, 0);
        pulse_start(1'b0);
        wait_halt("restart");
        chk("restart_pc", {21'b0, pc}, 32'h4);
        chk("restart_cycles", {16'b0, cycles}, 32'h5);

        // Restart from HALT, start ignored in RUN, remaining opcodes
        clear_mem();
        mem[0] = {5'b00010, 11'd7};
        mem[1] = {5'b00100, 11'd8};
        mem[2] = {5'b00110, 11'd9};
        mem[3] = {5'b00111, 11'd2};
        mem[4] = {5'b00101, 11'd4};
        mem[5] = {5'b00011, 11'd6};
        push(11'd0, 11'd7, 2'b00, 1, 0, 0, 0, 1, 0, 1);
        push(11'd1, 11'd8, 2'b10, 1, 0, 0, 1, 1, 0, 1);
        push(11'd2, 11'd9, 2'b10, 1, 0, 1, 1, 1, 0, 1);
        push(11'd3, 11'd2, 2'b10, 1, 1, 1, 1, 1, 0, 0);
        push(11'd4, 11'd4, 2'b10, 1, 1, 0, 1, 1, 0, 0);
        push(11'd5, 11'd6, 2'b01, 1, 0, 0, 0, 1, 0, 0);
        tick();
        pulse_start(1'b0);
        @(negedge clk);
        chk("hrst_pc", {21'b0, pc}, 32'h0);
        chk("hrst_cycles", {16'b0, cycles}, 32'h0);
        chk("hrst_running", {31'b0, running}, 32'h1);
        @(posedge clk); #1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("ign_start_pc", {21'b0, pc}, 32'h3);
        chk("ign_start_cycles", {16'b0, cycles}, 32'h3);
        wait_halt("ops");
        chk("ops_pc", {21'b0, pc}, 32'h6);
        chk("ops_cycles", {16'b0, cycles}, 32'h7);

        // No HLT: PC wrap and counter saturation
        for (int i = 0; i < 2048; i++) mem[i] = {5'b00011, 11'(i) ^ 11'h555};
        for (int n = 0; n <= 65536; n++)
            push(11'(n % 2048), 11'(n % 2048) ^ 11'h555, 2'b01, 1, 0, 0, 0, 1, 0, 0);
        tick();
        pulse_start(1'b0);
        for (int n = 0; n <= 65536; n++) begin
            @(negedge clk);
            if (n == 2047)  chk("wrap_pc_top", {21'b0, pc}, 32'h7FF);
            if (n == 2048)  chk("wrap_pc_zero", {21'b0, pc}, 32'h0);
            if (n == 65534) chk("sat_cycles_pre", {16'b0, cycles}, 32'hFFFE);
            if (n == 65535) chk("sat_cycles_max", {16'b0, cycles}, 32'hFFFF);
            if (n == 65536) chk("sat_cycles_hold", {16'b0, cycles}, 32'hFFFF);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("queue_empty", q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bip_control.md
# bip_control

Control unit for the BIP accumulator processor. It holds the program counter, fetches instructions from program memory, and decodes each 5-bit opcode into the datapath controls: selA, selB, wr_Acc, op, and the data-memory write/read strobes. It sequences execution from a start pulse until a HLT instruction, and supports a single-step debug mode. It counts executed instructions for the debug/UART reporting path.

## Interface
Parameters:
- NB_INSTR, 16, instruction width
- NB_OPCODE, 5, opcode field width (instr[15:11])
- NB_OPERAND, 11, operand field width (instr[10:0]); same as datapath NB_DATA_IN
- NB_PC, 11, program counter width
- NB_CYCLES, 16, executed-instruction counter width

Ports:
- i_clk  input  1  clock; all state updates on posedge
- i_reset  input  1  reset, asynchronous, active-high
- i_start  input  1  one-cycle pulse; starts execution from IDLE or HALT
- i_step_mode  input  1  1 = single-step; sampled only in IDLE/HALT when i_start=1
- i_step  input  1  one-cycle pulse; in step mode, allows one instruction to execute
- i_instr  input  NB_INSTR  program-memory data at address o_pc (asynchronous-read memory)
- o_pc  output  NB_PC  program-memory address
- o_operand  output  NB_OPERAND  instr[10:0], forwarded to datapath i_data
- o_selA  output  2  accumulator input mux: 00 dm, 01 immediate, 10 ALU
- o_selB  output  1  ALU B mux: 0 dm, 1 immediate
- o_wr_acc  output  1  accumulator write enable
- o_op  output  1  0 add, 1 sub
- o_wr_ram  output  1  data-memory write strobe
- o_rd_ram  output  1  data-memory read strobe
- o_running  output  1  state == RUN
- o_halt  output  1  state == HALT
- o_cycles  output  NB_CYCLES  number of instructions executed since last start

## Operation
States:
- IDLE (reset state)
- RUN
- HALT

Transitions:
- IDLE → RUN on i_start. Clears PC and o_cycles, and latches step mode.
- HALT → RUN on i_start. Same clearing and latching as from IDLE.
- RUN → HALT when a HLT instruction executes.
- i_start while in RUN is ignored.

Execute enable:
- exec = (state == RUN) && (!step_mode || i_step).
- With exec = 0, all strobes (o_wr_acc, o_wr_ram, o_rd_ram) are 0, and PC and o_cycles hold.
- o_selA, o_selB, o_op and o_operand always reflect the decode of i_instr. They are don't-care when exec = 0.

Decode (opcode → selA/selB/wr_acc/op/wr_ram/rd_ram):
- HLT 00000: all strobes 0. Moves to HALT; PC does not increment.
- STO 00001: wr_ram = 1.
- LD 00010: selA = 00, wr_acc = 1, rd_ram = 1.
- LDI 00011: selA = 01, wr_acc = 1.
- ADD 00100: selA = 10, selB = 0, op = 0, wr_acc = 1, rd_ram = 1.
- ADDI 00101: selA = 10, selB = 1, op = 0, wr_acc = 1.
- SUB 00110: selA = 10, selB = 0, op = 1, wr_acc = 1, rd_ram = 1.
- SUBI 00111: selA = 10, selB = 1, op = 1, wr_acc = 1.
- Any other opcode: NOP. All strobes 0; PC increments.

PC and counter:
- PC increments modulo 2^NB_PC on every exec cycle except HLT. It wraps from 0x7FF to 0x000 with no error.
- o_cycles increments on every exec cycle, HLT included, and saturates at all-ones.

## Timing
- Decode is combinational from i_instr, giving zero-cycle latency from o_pc to the control outputs.
- One instruction per exec cycle.
- PC, state and o_cycles update on the posedge that ends the exec cycle.
- The datapath captures the accumulator on the falling edge within that cycle. Controls must be stable from posedge to the following posedge.
- The i_start cycle itself executes nothing. The first instruction (PC 0) executes in the cycle after the transition to RUN.
- In step mode, i_step held high for N cycles executes N instructions.
- Reset asserted mid-RUN immediately forces IDLE, PC = 0, o_cycles = 0, and all strobes 0. Strobes deassert asynchronously.
- Reset values: o_pc 0, o_running 0, o_halt 0, o_cycles 0. Strobes are 0 because exec = 0.

## Structure
- bip_pkg holds:
  - opcode localparams (OP_HLT … OP_SUBI)
  - state encodings (ST_IDLE, ST_RUN, ST_HALT)
  - selA encodings (SELA_DM, SELA_IMM, SELA_ALU)
- Sub-module bip_instr_decoder: purely combinational, opcode → {selA, selB, op, wr_acc, wr_ram, rd_ram, is_hlt}.
- The top level holds the FSM, PC, counter and exec gating.

## Test plan
- Program LDI 5; ADDI 3; STO 10; HLT, then i_start in free-run → 4 exec cycles with o_selA 01, 10, –, – and o_wr_ram = 1 only on cycle 3 with o_operand = 10. Ends with o_halt = 1, o_pc = 3, o_cycles = 4.
- Step mode, same program, with i_step pulses at 3-cycle spacing → o_pc advances 0→1→2→3 only on pulse cycles, strobes are 0 between pulses, and HALT follows the 4th pulse.
- Opcode 11111 at PC 0 followed by HLT → NOP (strobes 0), PC goes to 1, then HALT with o_cycles = 2.
- i_reset asserted asynchronously mid-RUN at PC 2 → o_pc = 0, o_running = 0, and o_wr_acc drops before the next posedge. A subsequent i_start restarts at PC 0.
- i_start in HALT → RUN with o_pc = 0 and o_cycles = 0. An i_start pulse during RUN → no change to o_pc or o_cycles.
- Memory full of LDI (no HLT) → PC wraps from 0x7FF to 0x000. o_cycles saturates at 0xFFFF after 65535 exec cycles.
